// File: rtl/reset_sequencer.sv
// Power-on / soft-reset sequencer for NUM_DOMAINS downstream reset domains.
// After por_n deasserts, the domains are released one at a time starting with
// domain 0. Consecutive releases are at least REL_GAP cycles apart. Before the
// next release, the sequencer waits for the ready feedback of the domain it
// just released, for at most TMO further cycles. A soft reset request taken
// in DONE reasserts the domains from the highest index down, holds them all,
// pulses an acknowledge, and then runs the release sequence again.
//
// Ports:
//   clk         system clock, rising edge
//   por_n       asynchronous active-low power-on reset
//   ready       per-domain init-complete feedback
//   sw_rst_req  soft reset request (level), taken only in DONE
//   rst_n_out   per-domain active-low resets
//   sw_rst_ack  one-cycle pulse when the soft-reset hold completes
//   busy        a power-on or soft sequence is in progress
//   done        all domains released and the last check has passed
//   err         sticky per-domain ready timeout flags
module reset_sequencer #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned INIT_DLY    = 2,
    parameter int unsigned REL_GAP     = 3,
    parameter int unsigned TMO         = 8,
    parameter int unsigned SW_HOLD     = 4
) (
    input  logic                   clk,
    input  logic                   por_n,
    input  logic [NUM_DOMAINS-1:0] ready,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   sw_rst_ack,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_DOMAINS-1:0] err
);

    localparam int unsigned IdxW = (NUM_DOMAINS > 2) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DOMAINS - 1);

    // Terminal counts: a counter started at 0 on the entry edge reaches these
    // on the Nth following edge.
    localparam logic [7:0] InitLast = 8'(INIT_DLY - 1);
    localparam logic [7:0] GapLast  = 8'(REL_GAP - 1);
    localparam logic [7:0] TmoLast  = 8'(TMO - 1);
    localparam logic [7:0] HoldLast = 8'(SW_HOLD - 1);

    typedef enum logic [2:0] {
        StHold,
        StInit,
        StGap,
        StWaitRdy,
        StDone,
        StSwAssert,
        StSwHold
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [IdxW-1:0]        dom_q, dom_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic [NUM_DOMAINS-1:0] err_q, err_d;
    logic                   ack_q, ack_d;
    logic                   advance;
    logic [IdxW-1:0]        dom_nxt;

    assign dom_nxt = dom_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        rst_d   = rst_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        advance = 1'b0;

        unique case (state_q)
            StHold: begin
                state_d = StInit;
                cnt_d   = '0;
            end
            StInit: begin
                if (cnt_q == InitLast) begin
                    rst_d[0] = 1'b1;
                    dom_d    = '0;
                    cnt_d    = '0;
                    state_d  = StGap;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    if (ready[dom_q]) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = StWaitRdy;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWaitRdy: begin
                if (ready[dom_q]) begin
                    advance = 1'b1;
                end else if (cnt_q == TmoLast) begin
                    // Timed out: flag it and carry on with the sequence anyway.
                    err_d[dom_q] = 1'b1;
                    advance      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                if (sw_rst_req) begin
                    // The top domain is reasserted on the entry edge itself.
                    rst_d[LastIdx] = 1'b0;
                    dom_d          = LastIdx - 1'b1;
                    state_d        = StSwAssert;
                end
            end
            StSwAssert: begin
                rst_d[dom_q] = 1'b0;
                if (dom_q == '0) begin
                    cnt_d   = '0;
                    state_d = StSwHold;
                end else begin
                    dom_d = dom_q - 1'b1;
                end
            end
            StSwHold: begin
                if (cnt_q == HoldLast) begin
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StInit;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StHold;
            end
        endcase

        // Domain check passed (or timed out): release the next one or finish.
        if (advance) begin
            cnt_d = '0;
            if (dom_q == LastIdx) begin
                state_d = StDone;
            end else begin
                dom_d          = dom_nxt;
                rst_d[dom_nxt] = 1'b1;
                state_d        = StGap;
            end
        end
    end

    always_ff @(posedge clk or negedge por_n) begin
        if (!por_n) begin
            state_q <= StHold;
            cnt_q   <= '0;
            dom_q   <= '0;
            rst_q   <= '0;
            err_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            rst_q   <= rst_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

    assign rst_n_out  = rst_q;
    assign err        = err_q;
    assign sw_rst_ack = ack_q;
    assign done       = (state_q == StDone);
    assign busy       = ~done;

endmodule
